// File: rtl/test_sequencer_pkg.sv
// Shared phase codes, PS/2 set-2 key constants and the keyboard-check key order
// for the board test sequencer.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_BARS     = 3'd0,
        PH_AUDIO_L  = 3'd1,
        PH_AUDIO_R  = 3'd2,
        PH_KEYBOARD = 3'd3,
        PH_DONE     = 3'd4
    } phase_t;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Key the operator must press next, given how many of A-S-D already matched.
    function automatic logic [7:0] key_expected(input logic [1:0] idx);
        case (idx)
            2'd0:    key_expected = SC_A;
            2'd1:    key_expected = SC_S;
            default: key_expected = SC_D;
        endcase
    endfunction

endpackage

// File: rtl/test_sequencer_scancode_filter.sv
// Strips PS/2 break (F0) and extended (E0) prefixes; emits a registered strobe
// only for plain make codes, one cycle after the byte arrives.
module scancode_filter
    import test_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       make_valid,
    output logic [7:0] make_code
);

    logic brk;
    logic ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            make_valid <= 1'b0;
        end else begin
            make_valid <= 1'b0;
            if (scan_valid) begin
                if (scan_code == SC_BRK) begin
                    brk <= 1'b1;
                end else if (scan_code == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    make_valid <= !brk && !ext;
                    brk        <= 1'b0;
                    ext        <= 1'b0;
                end
            end
        end
    end

    // Code byte is qualified by make_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (scan_valid) begin
            make_code <= scan_code;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Operator-driven production test sequencer: steps through video bars, left and
// right audio, a keyboard A-S-D check and a done/blink phase from PS/2 make codes.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int CLK_HZ      = 7000000,
    parameter int AUDIO_TICKS = 21000000,
    parameter int BLINK_TICKS = 3500000,
    parameter int KEY_TIMEOUT = 70000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       mode,
    output logic       vga,
    output logic [2:0] phase,
    output logic       audio_en_l,
    output logic       audio_en_r,
    output logic       led,
    output logic       pass,
    output logic       fail
);

    localparam int CNT_MAX0 = (AUDIO_TICKS > BLINK_TICKS) ? AUDIO_TICKS : BLINK_TICKS;
    localparam int CNT_MAX  = (CNT_MAX0 > KEY_TIMEOUT) ? CNT_MAX0 : KEY_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] AUD_LAST   = CNT_W'(AUDIO_TICKS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             make_valid;
    logic [7:0]       make_code;
    phase_t           cur_phase;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       match_idx;

    logic hit_space, hit_bksp, hit_esc, hit_global;
    logic aud_last, blink_last, key_last;

    scancode_filter u_filter (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .make_valid (make_valid),
        .make_code  (make_code)
    );

    assign hit_space  = make_valid && (make_code == SC_SPACE);
    assign hit_bksp   = make_valid && (make_code == SC_BKSP);
    assign hit_esc    = make_valid && (make_code == SC_ESC);
    assign hit_global = make_valid && ((make_code == SC_F1) || (make_code == SC_F2));
    assign aud_last   = (cnt == AUD_LAST);
    assign blink_last = (cnt == BLINK_LAST);
    assign key_last   = (cnt == KEY_LAST);
    assign phase      = cur_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_phase  <= PH_BARS;
            mode       <= 1'b0;
            vga        <= 1'b0;
            audio_en_l <= 1'b0;
            audio_en_r <= 1'b0;
            led        <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            cnt        <= '0;
            match_idx  <= '0;
        end else begin
            if (make_valid && (make_code == SC_F1)) mode <= ~mode;
            if (make_valid && (make_code == SC_F2)) vga  <= ~vga;

            case (cur_phase)
                PH_BARS: begin
                    led        <= 1'b1;
                    audio_en_l <= 1'b0;
                    audio_en_r <= 1'b0;
                    cnt        <= '0;
                    if (hit_space) begin
                        cur_phase  <= PH_AUDIO_L;
                        audio_en_l <= 1'b1;
                        led        <= 1'b0;
                    end
                end
                PH_AUDIO_L: begin
                    if (hit_bksp) begin
                        cur_phase  <= PH_BARS;
                        audio_en_l <= 1'b0;
                        led        <= 1'b1;
                        cnt        <= '0;
                    end else if (hit_space || (!make_valid && aud_last)) begin
                        cur_phase  <= PH_AUDIO_R;
                        audio_en_l <= 1'b0;
                        audio_en_r <= 1'b1;
                        cnt        <= '0;
                    end else if (aud_last) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PH_AUDIO_R: begin
                    if (hit_bksp) begin
                        cur_phase  <= PH_AUDIO_L;
                        audio_en_r <= 1'b0;
                        audio_en_l <= 1'b1;
                        cnt        <= '0;
                    end else if (hit_space || (!make_valid && aud_last)) begin
                        cur_phase  <= PH_KEYBOARD;
                        audio_en_r <= 1'b0;
                        match_idx  <= '0;
                        cnt        <= '0;
                    end else if (aud_last) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PH_KEYBOARD: begin
                    if (hit_bksp) begin
                        cur_phase  <= PH_AUDIO_R;
                        audio_en_r <= 1'b1;
                        match_idx  <= '0;
                        cnt        <= '0;
                    end else if (make_valid) begin
                        // A key on the timeout cycle suppresses the timeout.
                        cnt <= key_last ? '0 : cnt + CNT_ONE;
                        if (!hit_global) begin
                            if (make_code == key_expected(match_idx)) begin
                                if (match_idx == 2'd2) begin
                                    cur_phase <= PH_DONE;
                                    pass      <= 1'b1;
                                    led       <= 1'b1;
                                    match_idx <= '0;
                                    cnt       <= '0;
                                end else begin
                                    match_idx <= match_idx + 2'd1;
                                end
                            end else begin
                                match_idx <= (make_code == SC_A) ? 2'd1 : 2'd0;
                            end
                        end
                    end else if (key_last) begin
                        cur_phase <= PH_DONE;
                        fail      <= 1'b1;
                        led       <= 1'b0;
                        match_idx <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PH_DONE: begin
                    if (hit_esc) begin
                        cur_phase <= PH_BARS;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        led       <= 1'b1;
                        cnt       <= '0;
                    end else if (hit_bksp) begin
                        cur_phase <= PH_KEYBOARD;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        led       <= 1'b0;
                        match_idx <= '0;
                        cnt       <= '0;
                    end else if (pass) begin
                        if (blink_last) begin
                            led <= ~led;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        led <= 1'b0;
                    end
                end
                default: begin
                    cur_phase  <= PH_BARS;
                    led        <= 1'b1;
                    audio_en_l <= 1'b0;
                    audio_en_r <= 1'b0;
                    pass       <= 1'b0;
                    fail       <= 1'b0;
                    match_idx  <= '0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer with short audio, blink and keyboard timeouts.
module tb_test_sequencer;

    logic       clk;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       mode;
    logic       vga;
    logic [2:0] phase;
    logic       audio_en_l;
    logic       audio_en_r;
    logic       led;
    logic       pass;
    logic       fail;

    int n_cmp = 0;
    int n_bad = 0;

    test_sequencer #(
        .CLK_HZ      (7000000),
        .AUDIO_TICKS (16),
        .BLINK_TICKS (4),
        .KEY_TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .mode       (mode),
        .vga        (vga),
        .phase      (phase),
        .audio_en_l (audio_en_l),
        .audio_en_r (audio_en_r),
        .led        (led),
        .pass       (pass),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte; returns 1 ns after the edge where the sequencer reacts.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        tick(2);
        check_val("rst_phase", phase, 0);
        check_val("rst_led", led, 0);
        check_val("rst_mode", mode, 0);
        check_val("rst_pass", pass, 0);
        rst = 1'b0;
        tick(1);
        check_val("rel_phase", phase, 0);
        check_val("rel_led", led, 1);
        check_val("rel_vga", vga, 0);
        check_val("rel_fail", fail, 0);
        check_val("rel_aud_l", audio_en_l, 0);

        send(8'hF0); send(8'h29);
        check_val("brk_space_phase", phase, 0);
        send(8'hE0); send(8'h05);
        check_val("ext_f1_mode", mode, 0);
        send(8'h05);
        check_val("f1_mode_on", mode, 1);
        check_val("f1_phase", phase, 0);
        send(8'h05);
        check_val("f1_mode_off", mode, 0);
        send(8'h06);
        check_val("f2_vga_on", vga, 1);
        send(8'h06);
        check_val("f2_vga_off", vga, 0);

        send(8'h29);
        check_val("bars_space_phase", phase, 1);
        send(8'h66);
        check_val("bksp_to_bars", phase, 0);
        check_val("bksp_bars_led", led, 1);
        check_val("bksp_bars_aud_l", audio_en_l, 0);

        send(8'h29);
        check_val("audl_phase", phase, 1);
        check_val("audl_en", audio_en_l, 1);
        check_val("audl_led", led, 0);
        tick(15);
        check_val("audl_hold", phase, 1);
        tick(1);
        check_val("audr_phase", phase, 2);
        check_val("audr_en_r", audio_en_r, 1);
        check_val("audr_en_l", audio_en_l, 0);
        tick(15);
        check_val("audr_hold", phase, 2);
        tick(1);
        check_val("kb_phase", phase, 3);
        check_val("kb_en_l", audio_en_l, 0);
        check_val("kb_en_r", audio_en_r, 0);

        send(8'h1C); send(8'h1B); send(8'h1C); send(8'h1B);
        check_val("kb_partial_phase", phase, 3);
        send(8'h23);
        check_val("done_phase", phase, 4);
        check_val("done_pass", pass, 1);
        check_val("done_fail", fail, 0);
        check_val("blink_t0", led, 1);
        tick(3);
        check_val("blink_t3", led, 1);
        tick(1);
        check_val("blink_t4", led, 0);
        tick(4);
        check_val("blink_t8", led, 1);
        send(8'h76);
        check_val("esc_phase", phase, 0);
        check_val("esc_pass", pass, 0);
        check_val("esc_led", led, 1);

        send(8'h29); send(8'h29); send(8'h29);
        check_val("kb2_phase", phase, 3);
        tick(63);
        check_val("kb_timeout_hold", phase, 3);
        tick(1);
        check_val("timeout_phase", phase, 4);
        check_val("timeout_fail", fail, 1);
        check_val("timeout_pass", pass, 0);
        check_val("timeout_led", led, 0);
        tick(5);
        check_val("timeout_led_steady", led, 0);
        send(8'h66);
        check_val("done_bksp_phase", phase, 3);
        check_val("done_bksp_fail", fail, 0);

        send(8'h66);
        check_val("kb_bksp_phase", phase, 2);
        send(8'h66);
        check_val("audr_bksp_phase", phase, 1);
        check_val("audr_bksp_en_l", audio_en_l, 1);
        // Space made visible to the sequencer on the AUDIO_L terminal-count cycle.
        tick(14);
        send(8'h29);
        check_val("collide_phase", phase, 2);
        check_val("collide_en_r", audio_en_r, 1);
        tick(15);
        check_val("collide_cnt_cleared", phase, 2);
        tick(1);
        check_val("collide_next_adv", phase, 3);

        send(8'h66);
        send(8'h05);
        check_val("pre_rst_phase", phase, 2);
        check_val("pre_rst_mode", mode, 1);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_phase", phase, 0);
        check_val("async_en_r", audio_en_r, 0);
        check_val("async_mode", mode, 0);
        check_val("async_led", led, 0);
        #2;
        rst = 1'b0;
        tick(1);
        check_val("post_rst_led", led, 1);
        check_val("post_rst_phase", phase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Operator-driven sequencer for the production board test.
- Consumes decoded PS/2 scancodes and steps the board through fixed test phases: video bars, left audio, right audio, keyboard check, done.
- Drives the video config (mode, vga), audio channel enables, the phase index for the message updater, and the test LED.
- Runs in the 7 MHz video clock domain, alongside the keyboard decoder and message updater.

Parameters:
- CLK_HZ, 7000000, clock frequency; documentation only, not used in logic.
- AUDIO_TICKS, 21000000, cycles each audio phase lasts before auto-advance (3 s at 7 MHz).
- BLINK_TICKS, 3500000, LED half-period in the DONE phase.
- KEY_TIMEOUT, 70000000, cycles allowed in the KEYBOARD phase before it fails.

Ports:
- clk  in  1  system clock (7 MHz).
- rst  in  1  asynchronous, active-high reset.
- scan_valid  in  1  one-cycle strobe: scan_code is a new byte.
- scan_code  in  8  raw PS/2 set-2 byte.
- mode  out  1  video standard select; also drives stdn/stdnb upstream.
- vga  out  1  scandoubler enable.
- phase  out  3  current phase code, for message selection.
- audio_en_l  out  1  left-channel tone enable.
- audio_en_r  out  1  right-channel tone enable.
- led  out  1  test LED.
- pass  out  1  high in DONE when the keyboard check succeeded.
- fail  out  1  high in DONE when the keyboard check timed out.

Behaviour:
- Reset (async, rst=1): phase=BARS, mode=0, vga=0, audio enables=0, led=0, pass=0, fail=0, all counters 0, prefix flags cleared.
- Scancode prefix filter:
  - 0xF0 sets brk; 0xE0 sets ext.
  - The next non-prefix byte is a "make" only if brk=0. Consumed bytes clear both flags.
  - Only makes with ext=0 act. Break and extended codes are discarded.
- Global keys, in any phase: F1 (0x05) toggles mode; F2 (0x06) toggles vga.
- States: BARS=0, AUDIO_L=1, AUDIO_R=2, KEYBOARD=3, DONE=4. Codes 5-7 are unreachable and recover to BARS on the next cycle.
- BARS:
  - Outputs: led=1, audio off.
  - Space (0x29) -> AUDIO_L.
- AUDIO_L:
  - Outputs: audio_en_l=1.
  - Tick counter runs. At count AUDIO_TICKS-1, or on Space -> AUDIO_R; counter cleared.
- AUDIO_R:
  - Same as AUDIO_L with audio_en_r=1, exiting to KEYBOARD.
- KEYBOARD:
  - Expects makes A (0x1C), S (0x1B), D (0x23) in that order.
  - Wrong key resets the match index to 0, except A, which sets it to 1.
  - Third match -> DONE with pass=1.
  - Timer reaching KEY_TIMEOUT-1 first -> DONE with fail=1.
  - Space is treated as a wrong key, not as advance.
- DONE:
  - pass/fail held.
  - LED toggles every BLINK_TICKS cycles when pass=1; steady 0 when fail=1.
  - Escape (0x76) -> BARS, clearing pass, fail and counters.
- Backspace (0x66) in any phase except BARS: go to the previous phase. From DONE it goes to KEYBOARD, clearing pass/fail and the keyboard match state.
- Timing and latency:
  - All outputs are registered.
  - Phase and outputs change the cycle after the accepted scan_valid, or the cycle after the terminal count.
- Simultaneous events:
  - A scan_valid key in the same cycle as a terminal count: the key wins, the timeout is ignored, counters are cleared.
  - mode/vga toggles never change the phase.
- Each phase counter clears on every phase entry.
- Counter widths are $clog2 of the largest parameter.

Decomposition:
- Shared package holds the phase codes (BARS..DONE) and key constants: SC_SPACE, SC_ESC, SC_BKSP, SC_F1, SC_F2, SC_A, SC_S, SC_D, SC_BRK, SC_EXT.
- The prefix filter is a natural sub-module: scancode_filter. Its outputs are make_valid and make_code, one cycle after scan_valid.
- Everything else stays in test_sequencer.

Test Plan:
- Bench parameters: AUDIO_TICKS=16, BLINK_TICKS=4, KEY_TIMEOUT=64.
- Reset release -> phase=0, led=1, mode=0, vga=0, pass=0, fail=0.
- Space make (0x29) in BARS -> phase=1, audio_en_l=1. After 16 cycles -> phase=2, audio_en_r=1, audio_en_l=0. After 16 more -> phase=3, both audio enables 0.
- Break sequence F0 29 in BARS -> phase stays 0. E0 05 -> mode unchanged. Bare 05 -> mode=1; 05 again -> mode=0. 06 -> vga=1.
- KEYBOARD: bytes 1C 1B 1C 1B 23 -> pass=1, phase=4, led toggles every 4 cycles. Then 76 -> phase=0, pass=0.
- KEYBOARD with no keys for 64 cycles -> phase=4, fail=1, led=0. Then 66 -> phase=3, fail=0.
- Space arriving on the same cycle as AUDIO_L terminal count -> a single advance to phase=2, counter 0. Async rst asserted mid-AUDIO_R -> outputs return to reset values immediately, with no clock edge.
